// File: rtl/traceback_engine_pkg.sv
// Shared types, default constants and derived-width helpers for the Viterbi
// traceback engine.
package traceback_engine_pkg;

   localparam int DEF_STATE_W  = 2;
   localparam int DEF_OUT_W    = 2;
   localparam int DEF_TB_DEPTH = 32;

   typedef enum logic [1:0] {
      S_FILL     = 2'd0,
      S_WAIT_SEL = 2'd1,
      S_TRACE    = 2'd2,
      S_OUT      = 2'd3
   } tb_state_e;

   function automatic int num_state_f(input int state_w);
      return 1 << state_w;
   endfunction

   // A depth of one still needs a one-bit pointer.
   function automatic int addr_w_f(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int len_w_f(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/traceback_engine_if.sv
// Survivor input, end-state selection and decoded-frame output of the
// traceback engine. master = ACS/downstream side, slave = engine.
interface traceback_engine_if
   import traceback_engine_pkg::*;
#(
   parameter int STATE_W  = DEF_STATE_W,
   parameter int OUT_W    = DEF_OUT_W,
   parameter int TB_DEPTH = DEF_TB_DEPTH
);
   localparam int NUM_STATE = num_state_f(STATE_W);
   localparam int LEN_W     = len_w_f(TB_DEPTH);

   logic                           i_srv_vld;
   logic                           o_srv_rdy;
   logic [NUM_STATE*STATE_W-1:0]   i_srv_prv_st;
   logic                           i_last;
   logic                           i_sel_vld;
   logic [STATE_W-1:0]             i_sel_node;
   logic                           o_valid;
   logic                           i_ready;
   logic [TB_DEPTH*OUT_W-1:0]      o_data;
   logic [LEN_W-1:0]               o_len;
   logic                           o_busy;

   modport master (
      output i_srv_vld, i_srv_prv_st, i_last, i_sel_vld, i_sel_node, i_ready,
      input  o_srv_rdy, o_valid, o_data, o_len, o_busy
   );

   modport slave (
      input  i_srv_vld, i_srv_prv_st, i_last, i_sel_vld, i_sel_node, i_ready,
      output o_srv_rdy, o_valid, o_data, o_len, o_busy
   );

endinterface

// File: rtl/traceback_engine_srv_mem.sv
// Survivor memory: one previous-state vector per trellis step. Synchronous
// write, combinational read of a single (step, node) entry. Not reset.
module traceback_engine_srv_mem
   import traceback_engine_pkg::*;
#(
   parameter int STATE_W  = DEF_STATE_W,
   parameter int TB_DEPTH = DEF_TB_DEPTH
)(
   input  logic                                    clk,
   input  logic                                    we_i,
   input  logic [addr_w_f(TB_DEPTH)-1:0]           waddr_i,
   input  logic [num_state_f(STATE_W)*STATE_W-1:0] wdata_i,
   input  logic [addr_w_f(TB_DEPTH)-1:0]           raddr_i,
   input  logic [STATE_W-1:0]                      rnode_i,
   output logic [STATE_W-1:0]                      rprv_o
);
   localparam int VEC_W = num_state_f(STATE_W) * STATE_W;

   logic [VEC_W-1:0] mem_q [TB_DEPTH];
   logic [VEC_W-1:0] rd_vec;

   // Store the incoming survivor vector at the write pointer.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Select the step, then the predecessor of the current node.
   always_comb begin
      rd_vec = mem_q[raddr_i];
      rprv_o = rd_vec[rnode_i*STATE_W +: STATE_W];
   end

endmodule

// File: rtl/traceback_engine.sv
// Viterbi traceback engine: buffers survivors for a frame, traces back from
// the selected end state and presents the decoded bits in step order.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_FILL     | accepting survivor vectors until i_last or a full buffer
// S_WAIT_SEL | frame closed, waiting for the traceback start state
// S_TRACE    | walking back one step per cycle, filling the output word
// S_OUT      | decoded frame presented until downstream accepts it
module traceback_engine
   import traceback_engine_pkg::*;
#(
   parameter int STATE_W  = DEF_STATE_W,
   parameter int OUT_W    = DEF_OUT_W,
   parameter int TB_DEPTH = DEF_TB_DEPTH
)(
   input  logic               clk,
   input  logic               rst,
   traceback_engine_if.slave  bus
);
   localparam int ADDR_W = addr_w_f(TB_DEPTH);
   localparam int LEN_W  = len_w_f(TB_DEPTH);
   localparam int DATA_W = TB_DEPTH * OUT_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(TB_DEPTH - 1);

   tb_state_e          state_q, state_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic [STATE_W-1:0] node_q, node_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               mem_we;
   logic [STATE_W-1:0] mem_rd;

   traceback_engine_srv_mem #(
      .STATE_W  (STATE_W),
      .TB_DEPTH (TB_DEPTH)
   ) u_srv_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.i_srv_prv_st),
      .raddr_i (idx_q),
      .rnode_i (node_q),
      .rprv_o  (mem_rd)
   );

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_FILL;
         wr_ptr_q <= '0;
         idx_q    <= '0;
         node_q   <= '0;
         len_q    <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         idx_q    <= idx_d;
         node_q   <= node_d;
         len_q    <= len_d;
         data_q   <= data_d;
      end
   end

   // Next-state and datapath updates for fill, select, trace and output.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      idx_d    = idx_q;
      node_d   = node_q;
      len_d    = len_q;
      data_d   = data_q;
      mem_we   = 1'b0;
      case (state_q)
         S_FILL: begin
            if (bus.i_srv_vld) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               // The last buffer slot closes the frame even without i_last.
               if (bus.i_last || (wr_ptr_q == LAST_PTR)) begin
                  len_d   = LEN_W'(wr_ptr_q) + LEN_W'(1);
                  state_d = S_WAIT_SEL;
               end
            end
         end
         S_WAIT_SEL: begin
            if (bus.i_sel_vld) begin
               node_d  = bus.i_sel_node;
               idx_d   = ADDR_W'(len_q - LEN_W'(1));
               data_d  = '0;
               state_d = S_TRACE;
            end
         end
         S_TRACE: begin
            data_d[idx_q*OUT_W +: OUT_W] = node_q[OUT_W-1:0];
            node_d = mem_rd;
            if (idx_q == '0) state_d = S_OUT;
            else             idx_d   = idx_q - ADDR_W'(1);
         end
         S_OUT: begin
            if (bus.i_ready) begin
               wr_ptr_d = '0;
               state_d  = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   assign bus.o_srv_rdy = (state_q == S_FILL);
   assign bus.o_busy    = (state_q != S_FILL);
   assign bus.o_valid   = (state_q == S_OUT);
   assign bus.o_data    = data_q;
   assign bus.o_len     = len_q;

endmodule

// File: tb/tb_traceback_engine.sv
// Bench for the traceback engine: a small (STATE_W=2, OUT_W=2, depth 4)
// instance for directed scenarios and a large (STATE_W=6, OUT_W=1, depth 32)
// instance for random frames, both checked against a software traceback.
module tb_traceback_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   traceback_engine_if #(.STATE_W(2), .OUT_W(2), .TB_DEPTH(4))  ifs ();
   traceback_engine_if #(.STATE_W(6), .OUT_W(1), .TB_DEPTH(32)) ifb ();

   traceback_engine #(.STATE_W(2), .OUT_W(2), .TB_DEPTH(4)) dut_s (
      .clk (clk), .rst (rst), .bus (ifs)
   );
   traceback_engine #(.STATE_W(6), .OUT_W(1), .TB_DEPTH(32)) dut_b (
      .clk (clk), .rst (rst), .bus (ifb)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // survivor tables: sv[step][state] = predecessor state
   int sv_s [4][4];
   int sv_b [32][64];

   // ---------------- small instance helpers ----------------
   function automatic logic [7:0] pack_s(input int step);
      logic [7:0] v;
      for (int s = 0; s < 4; s++) v[s*2 +: 2] = 2'(sv_s[step][s]);
      return v;
   endfunction

   function automatic logic [7:0] model_s(input int len, input int sel);
      logic [7:0] e;
      int node;
      e = '0;
      node = sel;
      for (int j = len - 1; j >= 0; j--) begin
         e[j*2 +: 2] = 2'(node % 4);
         node = sv_s[j][node];
      end
      return e;
   endfunction

   task automatic fill_rand_s(input int len);
      for (int j = 0; j < len; j++)
         for (int s = 0; s < 4; s++) sv_s[j][s] = int'($urandom_range(0, 3));
   endtask

   task automatic push_s(input int step, input bit last);
      int n;
      n = 0;
      ifs.i_srv_prv_st = pack_s(step);
      ifs.i_last       = last;
      ifs.i_srv_vld    = 1'b1;
      while (ifs.o_srv_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      n_checks++;
      if (n >= 50) begin
         n_fail++;
         $display("FAIL push_s_timeout: step %0d waited %0d cycles, required < 50", step, n);
      end
      @(negedge clk);
      ifs.i_srv_vld = 1'b0;
      ifs.i_last    = 1'b0;
   endtask

   task automatic send_s(input int len, input bit use_last);
      for (int j = 0; j < len; j++) push_s(j, use_last && (j == len - 1));
   endtask

   task automatic select_s(input int sel);
      ifs.i_sel_node = 2'(sel);
      ifs.i_sel_vld  = 1'b1;
      @(negedge clk);
      ifs.i_sel_vld  = 1'b0;
   endtask

   task automatic decode_s(input string name, input int len, input int sel);
      int cyc;
      logic [7:0] exp_d;
      exp_d = model_s(len, sel);
      select_s(sel);
      cyc = 1;
      while (ifs.o_valid !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
      n_checks++;
      if (cyc != len + 1) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc, len + 1);
      end
      n_checks++;
      if (ifs.o_data !== exp_d) begin
         n_fail++;
         $display("FAIL %s_data: got %h, required %h", name, ifs.o_data, exp_d);
      end
      n_checks++;
      if (ifs.o_len !== 3'(len)) begin
         n_fail++;
         $display("FAIL %s_len: got %0d, required %0d", name, ifs.o_len, len);
      end
   endtask

   task automatic accept_s(input string name);
      ifs.i_ready = 1'b1;
      @(negedge clk);
      ifs.i_ready = 1'b0;
      n_checks++;
      if (ifs.o_valid !== 1'b0 || ifs.o_srv_rdy !== 1'b1 || ifs.o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_accept: valid/rdy/busy got %b%b%b, required 010",
                  name, ifs.o_valid, ifs.o_srv_rdy, ifs.o_busy);
      end
   endtask

   // ---------------- large instance helpers ----------------
   function automatic logic [383:0] pack_b(input int step);
      logic [383:0] v;
      for (int s = 0; s < 64; s++) v[s*6 +: 6] = 6'(sv_b[step][s]);
      return v;
   endfunction

   function automatic logic [31:0] model_b(input int len, input int sel);
      logic [31:0] e;
      int node;
      e = '0;
      node = sel;
      for (int j = len - 1; j >= 0; j--) begin
         e[j] = 1'(node % 2);
         node = sv_b[j][node];
      end
      return e;
   endfunction

   task automatic push_b(input int step, input bit last);
      int n;
      n = 0;
      ifb.i_srv_prv_st = pack_b(step);
      ifb.i_last       = last;
      ifb.i_srv_vld    = 1'b1;
      while (ifb.o_srv_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      n_checks++;
      if (n >= 50) begin
         n_fail++;
         $display("FAIL push_b_timeout: step %0d waited %0d cycles, required < 50", step, n);
      end
      @(negedge clk);
      ifb.i_srv_vld = 1'b0;
      ifb.i_last    = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_checks++;
      if (ifs.o_valid !== 1'b0 || ifb.o_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b/%b, required 0/0", ifs.o_valid, ifb.o_valid);
      end
      n_checks++;
      if (ifs.o_data !== 8'h00 || ifb.o_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_data: got %h/%h, required 0", ifs.o_data, ifb.o_data);
      end
      n_checks++;
      if (ifs.o_len !== 3'd0 || ifb.o_len !== 6'd0) begin
         n_fail++; $display("FAIL reset_len: got %0d/%0d, required 0", ifs.o_len, ifb.o_len);
      end
      n_checks++;
      if (ifs.o_busy !== 1'b0 || ifb.o_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b/%b, required 0", ifs.o_busy, ifb.o_busy);
      end
      n_checks++;
      if (ifs.o_srv_rdy !== 1'b1 || ifb.o_srv_rdy !== 1'b1) begin
         n_fail++; $display("FAIL reset_srv_rdy: got %b/%b, required 1", ifs.o_srv_rdy, ifb.o_srv_rdy);
      end
   endtask

   task automatic test_full_frame();
      for (int j = 0; j < 4; j++)
         for (int s = 0; s < 4; s++) sv_s[j][s] = (s + 1) % 4;
      send_s(4, 1'b0);
      n_checks++;
      if (ifs.o_busy !== 1'b1 || ifs.o_srv_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_close: busy/rdy got %b%b, required 10", ifs.o_busy, ifs.o_srv_rdy);
      end
      decode_s("full", 4, 0);
      n_checks++;
      if (ifs.o_data !== 8'h1B) begin
         n_fail++; $display("FAIL full_const: got %h, required 1b", ifs.o_data);
      end
      accept_s("full");
   endtask

   task automatic test_short_frame();
      for (int j = 0; j < 2; j++)
         for (int s = 0; s < 4; s++) sv_s[j][s] = s;
      send_s(2, 1'b1);
      n_checks++;
      if (ifs.o_srv_rdy !== 1'b0 || ifs.o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL short_wait_sel: rdy/busy got %b%b, required 01", ifs.o_srv_rdy, ifs.o_busy);
      end
      decode_s("short", 2, 2);
      n_checks++;
      if (ifs.o_data !== 8'h0A || ifs.o_srv_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL short_out: data %h rdy %b, required 0a rdy 0", ifs.o_data, ifs.o_srv_rdy);
      end
      accept_s("short");
   endtask

   task automatic test_backpressure();
      logic [7:0] held;
      int sel;
      fill_rand_s(3);
      send_s(3, 1'b1);
      decode_s("bp", 3, int'($urandom_range(0, 3)));
      held = ifs.o_data;
      // next frame's only vector is offered while the current one is held
      for (int s = 0; s < 4; s++) sv_s[0][s] = int'($urandom_range(0, 3));
      ifs.i_srv_prv_st = pack_s(0);
      ifs.i_srv_vld    = 1'b1;
      ifs.i_last       = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (ifs.o_valid !== 1'b1 || ifs.o_data !== held || ifs.o_len !== 3'd3 ||
             ifs.o_srv_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: cyc %0d valid %b data %h len %0d rdy %b, required 1 %h 3 0",
                     k, ifs.o_valid, ifs.o_data, ifs.o_len, ifs.o_srv_rdy, held);
         end
      end
      ifs.i_ready = 1'b1;
      @(negedge clk);
      ifs.i_ready = 1'b0;
      n_checks++;
      if (ifs.o_valid !== 1'b0 || ifs.o_srv_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: valid/rdy got %b%b, required 01", ifs.o_valid, ifs.o_srv_rdy);
      end
      @(negedge clk);
      ifs.i_srv_vld = 1'b0;
      ifs.i_last    = 1'b0;
      n_checks++;
      if (ifs.o_busy !== 1'b1) begin
         n_fail++; $display("FAIL bp_next_close: busy got %b, required 1", ifs.o_busy);
      end
      sel = int'($urandom_range(0, 3));
      decode_s("bp_next", 1, sel);
      accept_s("bp_next");
   endtask

   task automatic test_async_reset();
      int len;
      for (int j = 0; j < 4; j++)
         for (int s = 0; s < 4; s++) sv_s[j][s] = (s + 1) % 4;
      send_s(4, 1'b0);
      select_s(0);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (ifs.o_busy !== 1'b1) begin
         n_fail++; $display("FAIL ar_pre_busy: got %b, required 1", ifs.o_busy);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (ifs.o_valid !== 1'b0 || ifs.o_data !== 8'h00 || ifs.o_busy !== 1'b0 ||
          ifs.o_len !== 3'd0) begin
         n_fail++;
         $display("FAIL ar_immediate: valid %b data %h busy %b len %0d, required 0 00 0 0",
                  ifs.o_valid, ifs.o_data, ifs.o_busy, ifs.o_len);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      len = int'($urandom_range(1, 4));
      fill_rand_s(len);
      send_s(len, 1'b1);
      decode_s("ar_next", len, int'($urandom_range(0, 3)));
      accept_s("ar_next");
   endtask

   task automatic test_back_to_back();
      int len;
      for (int f = 0; f < 6; f++) begin
         len = int'($urandom_range(1, 4));
         fill_rand_s(len);
         push_s(0, len == 1);
         if (len > 1) begin
            select_s(int'($urandom_range(0, 3)));
            n_checks++;
            if (ifs.o_busy !== 1'b0 || ifs.o_srv_rdy !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_early_sel: busy/rdy got %b%b, required 01", ifs.o_busy, ifs.o_srv_rdy);
            end
            for (int j = 1; j < len; j++) push_s(j, (len < 4) && (j == len - 1));
         end
         decode_s("b2b", len, int'($urandom_range(0, 3)));
         accept_s("b2b");
      end
   endtask

   task automatic test_random_big();
      int len, sel, cyc;
      bit use_last;
      logic [31:0] exp_d;
      for (int f = 0; f < 200; f++) begin
         len = int'($urandom_range(1, 32));
         use_last = (len < 32) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int j = 0; j < len; j++)
            for (int s = 0; s < 64; s++) sv_b[j][s] = int'($urandom_range(0, 63));
         for (int j = 0; j < len; j++) push_b(j, use_last && (j == len - 1));
         sel = int'($urandom_range(0, 63));
         exp_d = model_b(len, sel);
         ifb.i_sel_node = 6'(sel);
         ifb.i_sel_vld  = 1'b1;
         @(negedge clk);
         ifb.i_sel_vld  = 1'b0;
         cyc = 1;
         while (ifb.o_valid !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
         n_checks++;
         if (cyc != len + 1) begin
            n_fail++;
            $display("FAIL rnd_latency: frame %0d got %0d cycles, required %0d", f, cyc, len + 1);
         end
         n_checks++;
         if (ifb.o_data !== exp_d) begin
            n_fail++;
            $display("FAIL rnd_data: frame %0d len %0d got %h, required %h", f, len, ifb.o_data, exp_d);
         end
         n_checks++;
         if (ifb.o_len !== 6'(len)) begin
            n_fail++;
            $display("FAIL rnd_len: frame %0d got %0d, required %0d", f, ifb.o_len, len);
         end
         ifb.i_ready = 1'b1;
         @(negedge clk);
         ifb.i_ready = 1'b0;
      end
   endtask

   initial begin
      ifs.i_srv_vld = 1'b0; ifs.i_srv_prv_st = '0; ifs.i_last = 1'b0;
      ifs.i_sel_vld = 1'b0; ifs.i_sel_node = '0;   ifs.i_ready = 1'b0;
      ifb.i_srv_vld = 1'b0; ifb.i_srv_prv_st = '0; ifb.i_last = 1'b0;
      ifb.i_sel_vld = 1'b0; ifb.i_sel_node = '0;   ifb.i_ready = 1'b0;
      #1;
      test_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_full_frame();
      test_short_frame();
      test_backpressure();
      test_async_reset();
      test_back_to_back();
      test_random_big();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
